// File: rtl/shared_dm_if.sv
// rtl/shared_dm_if.sv - core and host bus bundle for the shared data-memory controller
interface shared_dm_if #(
    parameter int NUM_CORES = 4,
    parameter int AW        = 8,
    parameter int DW        = 16
);
    logic                      start;
    logic [NUM_CORES*DW-1:0]   core_addr;
    logic [NUM_CORES*DW-1:0]   core_wdata;
    logic [NUM_CORES-1:0]      core_we;
    logic [NUM_CORES-1:0]      core_end;
    logic [NUM_CORES*DW-1:0]   core_dm_out;
    logic [NUM_CORES*2-1:0]    core_status;
    logic                      ext_we;
    logic [AW-1:0]             ext_addr;
    logic [DW-1:0]             ext_wdata;
    logic [DW-1:0]             ext_rdata;
    logic                      busy;
    logic                      all_done;

    modport master (
        output start, core_addr, core_wdata, core_we, core_end,
        output ext_we, ext_addr, ext_wdata,
        input  core_dm_out, core_status, ext_rdata, busy, all_done
    );

    modport slave (
        input  start, core_addr, core_wdata, core_we, core_end,
        input  ext_we, ext_addr, ext_wdata,
        output core_dm_out, core_status, ext_rdata, busy, all_done
    );
endinterface

// File: rtl/shared_dm_ctrl.sv
// rtl/shared_dm_ctrl.sv - shared data RAM with per-core read ports and round-robin write port
module shared_dm_ctrl #(
    parameter int NUM_CORES = 4,
    parameter int AW        = 8,
    parameter int DW        = 16
) (
    input logic        clk,
    input logic        rst,
    shared_dm_if.slave bus
);
    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [PW-1:0] LAST = PW'(NUM_CORES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic [DW-1:0]        mem [2**AW];
    logic [NUM_CORES-1:0] buf_valid;
    logic [NUM_CORES-1:0] done;
    logic [NUM_CORES-1:0] capture;
    logic [AW-1:0]        buf_addr [NUM_CORES];
    logic [DW-1:0]        buf_data [NUM_CORES];
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        grant;
    logic                 grant_valid;
    logic                 clear_run;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^bus.core_addr;

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CORES) s = s - NUM_CORES;
        return PW'(s);
    endfunction

    // Walk from the farthest offset back to rr_ptr so the nearest valid buffer wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (buf_valid[wrap_idx(rr_ptr, k)]) begin
                grant       = wrap_idx(rr_ptr, k);
                grant_valid = 1'b1;
            end
        end
    end

    always_comb begin
        capture = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            capture[i] = (state == RUN) && bus.core_we[i] && !buf_valid[i] && !done[i];
        end
    end

    always_comb begin
        state_nxt = state;
        clear_run = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                state_nxt = RUN;
                clear_run = 1'b1;
            end
            RUN:  if ((&done) && !(|buf_valid)) state_nxt = DONE;
            DONE: if (bus.start) begin
                state_nxt = RUN;
                clear_run = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.core_status = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (state == DONE)           bus.core_status[2*i +: 2] = 2'b11;
            else if (state == RUN) begin
                if (buf_valid[i])        bus.core_status[2*i +: 2] = 2'b10;
                else if (done[i])        bus.core_status[2*i +: 2] = 2'b11;
                else                     bus.core_status[2*i +: 2] = 2'b01;
            end
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.all_done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            buf_valid <= '0;
            done      <= '0;
            rr_ptr    <= '0;
        end else begin
            state <= state_nxt;
            if (clear_run) begin
                done   <= '0;
                rr_ptr <= '0;
            end else if (state == RUN) begin
                done <= done | bus.core_end;
                if (grant_valid) rr_ptr <= (grant == LAST) ? '0 : grant + 1'b1;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (capture[i])                                 buf_valid[i] <= 1'b1;
                else if (grant_valid && grant == PW'(i))        buf_valid[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            if (capture[i]) begin
                buf_addr[i] <= bus.core_addr[i*DW +: AW];
                buf_data[i] <= bus.core_wdata[i*DW +: DW];
            end
        end
    end

    // Core commits only happen in RUN and host writes only outside RUN, so they never collide.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == RUN && grant_valid)      mem[buf_addr[grant]] <= buf_data[grant];
            else if (state != RUN && bus.ext_we)  mem[bus.ext_addr]    <= bus.ext_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.core_dm_out <= '0;
            bus.ext_rdata   <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                bus.core_dm_out[i*DW +: DW] <= mem[bus.core_addr[i*DW +: AW]];
            end
            bus.ext_rdata <= mem[bus.ext_addr];
        end
    end
endmodule

// File: tb/tb_shared_dm_ctrl.sv
// tb/tb_shared_dm_ctrl.sv - scoreboard bench for shared_dm_ctrl
module tb_shared_dm_ctrl;
    localparam int NC = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    localparam int K_STAT = 0;
    localparam int K_DM   = 1;
    localparam int K_EXT  = 2;
    localparam int K_BUSY = 3;
    localparam int K_DONE = 4;

    typedef struct {
        int stamp;
        int kind;
        int idx;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    shared_dm_if #(.NUM_CORES(NC), .AW(AW), .DW(DW)) bus ();

    shared_dm_ctrl #(.NUM_CORES(NC), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kind_name(input int k);
        case (k)
            K_STAT:  return "status";
            K_DM:    return "dm_out";
            K_EXT:   return "ext_rdata";
            K_BUSY:  return "busy";
            default: return "all_done";
        endcase
    endfunction

    function automatic int actual(input int k, input int i);
        case (k)
            K_STAT:  return int'(bus.core_status[2*i +: 2]);
            K_DM:    return int'(bus.core_dm_out[i*DW +: DW]);
            K_EXT:   return int'(bus.ext_rdata);
            K_BUSY:  return int'(bus.busy);
            default: return int'(bus.all_done);
        endcase
    endfunction

    // Monitor: compare every expectation stamped for the current cycle, away from the edge.
    always @(negedge clk) begin
        exp_t keep[$];
        keep = {};
        foreach (sb[j]) begin
            if (sb[j].stamp == cyc) begin
                n_cmp++;
                if (actual(sb[j].kind, sb[j].idx) !== sb[j].val) begin
                    n_bad++;
                    $display("FAIL %s[%0d] cycle %0d: got %h expected %h", kind_name(sb[j].kind),
                             sb[j].idx, cyc, actual(sb[j].kind, sb[j].idx), sb[j].val);
                end
            end else if (sb[j].stamp < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s[%0d] stale expectation for cycle %0d", kind_name(sb[j].kind),
                         sb[j].idx, sb[j].stamp);
            end else begin
                keep.push_back(sb[j]);
            end
        end
        sb = keep;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic expect_v(input int d, input int k, input int i, input int v);
        exp_t e;
        e.stamp = cyc + d;
        e.kind  = k;
        e.idx   = i;
        e.val   = v;
        sb.push_back(e);
    endtask

    task automatic expect_all_status(input int d, input int v);
        for (int i = 0; i < NC; i++) expect_v(d, K_STAT, i, v);
    endtask

    task automatic set_core(input int i, input int addr, input int data, input bit we, input bit en);
        bus.core_addr[i*DW +: DW]  = DW'(addr);
        bus.core_wdata[i*DW +: DW] = DW'(data);
        bus.core_we[i]             = we;
        bus.core_end[i]            = en;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.core_addr = '0;
        bus.core_wdata = '0;
        bus.core_we = '0;
        bus.core_end = '0;
        bus.ext_we = 1'b0;
        bus.ext_addr = '0;
        bus.ext_wdata = '0;

        ticks(2);
        rst = 1'b0;
        expect_all_status(0, 0);
        for (int i = 0; i < NC; i++) expect_v(0, K_DM, i, 0);
        expect_v(0, K_EXT, 0, 0);
        expect_v(0, K_BUSY, 0, 0);
        expect_v(0, K_DONE, 0, 0);

        // Host preload and readback in IDLE.
        bus.ext_we = 1'b1; bus.ext_addr = 8'd3; bus.ext_wdata = 16'h00A5;
        tick();
        bus.ext_addr = 8'd7; bus.ext_wdata = 16'h0001;
        tick();
        bus.ext_we = 1'b0; bus.ext_addr = 8'd3;
        expect_v(1, K_EXT, 0, 16'h00A5);
        expect_all_status(1, 0);
        tick();

        bus.start = 1'b1;
        expect_all_status(1, 1);
        expect_v(1, K_BUSY, 0, 1);
        tick();
        bus.start = 1'b0;

        // Uncontended write: one-cycle WAIT, data readable afterwards.
        set_core(1, 16'h0010, 16'h1234, 1'b1, 1'b0);
        tick();
        expect_v(0, K_STAT, 1, 2);
        expect_v(0, K_STAT, 0, 1);
        set_core(1, 16'h0010, 0, 1'b0, 1'b0);
        expect_v(1, K_STAT, 1, 1);
        expect_v(2, K_DM, 1, 16'h1234);
        ticks(2);

        // All four cores contend with rr_ptr=2: commit order 2,3,0,1.
        for (int i = 0; i < NC; i++) set_core(i, 16'h0020, 16'h00C0 + i, 1'b1, 1'b0);
        tick();
        expect_all_status(0, 2);
        expect_v(1, K_STAT, 2, 1); expect_v(1, K_STAT, 3, 2);
        expect_v(2, K_STAT, 3, 1); expect_v(2, K_STAT, 0, 2);
        expect_v(3, K_STAT, 0, 1); expect_v(3, K_STAT, 1, 2);
        expect_v(4, K_STAT, 1, 1);
        expect_v(4, K_DM, 0, 16'h00C0);
        expect_v(5, K_DM, 0, 16'h00C1);
        bus.core_we = '0;
        ticks(5);

        // Read-during-write returns old data; host write in RUN is ignored.
        bus.ext_we = 1'b1; bus.ext_addr = 8'd7; bus.ext_wdata = 16'hFFFF;
        set_core(2, 16'h0007, 16'h0002, 1'b1, 1'b0);
        set_core(3, 16'h0007, 0, 1'b0, 1'b0);
        tick();
        expect_v(0, K_STAT, 2, 2);
        expect_v(0, K_DM, 3, 16'h0001);
        bus.core_we = '0;
        expect_v(1, K_STAT, 2, 1);
        expect_v(1, K_DM, 3, 16'h0001);
        expect_v(1, K_EXT, 0, 16'h0001);
        expect_v(2, K_DM, 3, 16'h0002);
        expect_v(2, K_EXT, 0, 16'h0002);
        ticks(2);
        bus.ext_we = 1'b0;
        tick();

        // End handling: cores 1..3 finish, then core 0 ends with a pending write.
        bus.core_end = 4'b1110;
        tick();
        bus.core_end = '0;
        expect_v(0, K_STAT, 1, 3); expect_v(0, K_STAT, 2, 3); expect_v(0, K_STAT, 3, 3);
        expect_v(0, K_STAT, 0, 1);
        expect_v(0, K_BUSY, 0, 1);
        set_core(0, 16'h0005, 16'hBEEF, 1'b1, 1'b1);
        set_core(1, 16'h0005, 0, 1'b0, 1'b0);
        tick();
        bus.core_we = '0; bus.core_end = '0;
        expect_v(0, K_STAT, 0, 2);
        expect_v(0, K_DONE, 0, 0);
        expect_v(1, K_STAT, 0, 3);
        expect_v(1, K_DONE, 0, 0);
        expect_v(1, K_BUSY, 0, 1);
        expect_v(2, K_DONE, 0, 1);
        expect_v(2, K_BUSY, 0, 0);
        expect_v(2, K_DM, 1, 16'hBEEF);
        expect_all_status(2, 3);
        ticks(3);

        // DONE: host writes are accepted, then relaunch.
        bus.ext_we = 1'b1;
        bus.ext_addr = 8'h30; bus.ext_wdata = 16'h1111; tick();
        bus.ext_addr = 8'h31; bus.ext_wdata = 16'h2222; tick();
        bus.ext_addr = 8'h32; bus.ext_wdata = 16'h3333; tick();
        bus.ext_we = 1'b0; bus.ext_addr = 8'h30;
        expect_v(1, K_EXT, 0, 16'h1111);
        tick();
        bus.start = 1'b1;
        expect_all_status(1, 1);
        expect_v(1, K_BUSY, 0, 1);
        expect_v(1, K_DONE, 0, 0);
        tick();
        bus.start = 1'b0;

        // Reset with three buffered writes pending: none may reach RAM.
        for (int i = 0; i < 3; i++) set_core(i, 16'h0030 + i, 16'hD000 + i, 1'b1, 1'b0);
        tick();
        expect_v(0, K_STAT, 0, 2); expect_v(0, K_STAT, 1, 2); expect_v(0, K_STAT, 2, 2);
        bus.core_we = '0;
        rst = 1'b1;
        expect_all_status(1, 0);
        for (int i = 0; i < NC; i++) expect_v(1, K_DM, i, 0);
        expect_v(1, K_EXT, 0, 0);
        expect_v(1, K_BUSY, 0, 0);
        expect_v(1, K_DONE, 0, 0);
        tick();
        rst = 1'b0;
        bus.ext_addr = 8'h30; expect_v(1, K_EXT, 0, 16'h1111); tick();
        bus.ext_addr = 8'h31; expect_v(1, K_EXT, 0, 16'h2222); tick();
        bus.ext_addr = 8'h32; expect_v(1, K_EXT, 0, 16'h3333); tick();
        bus.start = 1'b1;
        expect_all_status(1, 1);
        tick();
        bus.start = 1'b0;
        ticks(3);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/shared_dm_ctrl.md
Name: shared_dm_ctrl

Overview:
Shared data-memory controller that sits directly downstream of the processor cores.
- Consumes each core's address (AR_out), write data (bus), DM_write_en and end_process.
- Returns per-core DM_out and the 2-bit status word that gates each core.
- Holds one on-chip data RAM; reads are multi-ported, writes are serialized through one round-robin-arbitrated port.
- A host-side port preloads and reads back memory while the cores are idle.

Parameters:
- NUM_CORES, 4, number of processor cores served.
- AW, 8, RAM address width; depth = 2**AW words; core addresses use bits [AW-1:0], upper bits ignored.
- DW, 16, data word width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: launch (or relaunch) all cores.
- core_addr  in  NUM_CORES*DW  per-core AR_out, core i at [i*DW +: DW].
- core_wdata  in  NUM_CORES*DW  per-core bus value (write data).
- core_we  in  NUM_CORES  per-core DM_write_en.
- core_end  in  NUM_CORES  per-core end_process.
- core_dm_out  out  NUM_CORES*DW  per-core read data (DM_out).
- core_status  out  NUM_CORES*2  per-core status: 00 HOLD, 01 RUN, 10 WAIT, 11 DONE.
- ext_we  in  1  host write enable.
- ext_addr  in  AW  host address.
- ext_wdata  in  DW  host write data.
- ext_rdata  out  DW  host read data.
- busy  out  1  high while in RUN.
- all_done  out  1  high in DONE.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (rst=1 at a clk edge) forces:
  - state IDLE; all write buffers, done flags and rr_ptr cleared.
  - core_dm_out=0, core_status=00 for all cores, ext_rdata=0, busy=0, all_done=0.
  - RAM contents are not reset.
  - Reset mid-RUN discards buffered writes that have not yet been committed.
- IDLE:
  - All status=00.
  - The ext port is active.
  - start moves to RUN; from the next cycle every status=01 and busy=1.
- Reads:
  - Every cycle, core_dm_out[i] <= RAM[core_addr[i][AW-1:0]], giving 1-cycle latency for every core in every state.
  - ext_rdata <= RAM[ext_addr] with the same 1-cycle latency.
  - Read and write to the same address in the same cycle returns the old data; the new data is visible the next cycle.
- Writes:
  - Each core has a 1-entry buffer (valid, addr, data).
  - In RUN, core_we[i]=1 with status[i]=01 captures addr/data at the edge, and status[i] becomes 10 (WAIT).
  - core_we while in WAIT, DONE or HOLD is ignored.
  - Each cycle the arbiter grants the first valid buffer at index >= rr_ptr, wrapping modulo NUM_CORES.
  - On a grant, the entry is written to RAM at the edge, the buffer is cleared, rr_ptr <= grant+1 mod NUM_CORES, and status[grant] <= 01 (or 11 if that core is done).
  - Uncontended write: WAIT lasts exactly 1 cycle. Worst case is NUM_CORES cycles.
  - No grant is issued in a cycle with no valid buffer; rr_ptr holds.
- Ext writes:
  - ext_we commits at the edge in IDLE or DONE.
  - ext_we is ignored in RUN.
- End handling:
  - core_end[i]=1 in RUN sets sticky done[i].
  - status[i] becomes 11 once the buffer is empty.
  - core_end and core_we in the same cycle: the write is captured, status goes 10, then 11 after commit.
- RUN -> DONE when all done[] are set and no buffer is valid. all_done=1 and busy=0 from the following cycle; statuses stay 11.
- DONE:
  - start clears done[] and rr_ptr, then enters RUN with all statuses 01.
  - start in RUN is ignored.

Test Plan:
- Preload and readback: in IDLE, ext write 0x00A5 to addr 3 -> ext_addr=3 gives ext_rdata=0x00A5 one cycle later; core_status all 00 until start.
- Uncontended write: core 1 writes 0x1234 to addr 0x10 at cycle t -> status1 = 10 for cycle t+1 only, 01 at t+2; core_dm_out1 = 0x1234 when reading addr 0x10 at t+2.
- Round-robin contention: all 4 cores write addr 0x20 with data 0xC0..0xC3 in the same cycle, rr_ptr=2 -> commit order 2,3,0,1; final RAM[0x20]=0xC1; WAITs last 1, 2, 3 and 4 cycles respectively.
- End with pending write: core 0 asserts core_end and core_we (addr 5, 0xBEEF) together, others already done -> status0 10 then 11; all_done rises only after RAM[5]=0xBEEF is committed.
- Ext write in RUN is ignored, and read-during-write returns old data: RAM[7]=0x0001, core 2 writes 0x0002 while core 3 reads 7 in the commit cycle -> core_dm_out3 shows 0x0001, then 0x0002 the next cycle; a concurrent ext_we to addr 7 has no effect.
- Reset mid-RUN with 3 buffers valid -> next cycle state IDLE, all outputs 0, and no buffered data is written to RAM; then start -> all statuses 01.
